// File: rtl/gbn_tx_scheduler.sv
// Go-Back-N transmit scheduler: buffers unacked frames, sequences them onto the
// link, consumes cumulative ACKs and rewinds to the oldest unacked frame on timeout.
module gbn_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int SEQ_BITS    = 3,
    parameter int WINDOW_SIZE = 4,
    parameter int TIMEOUT     = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [SEQ_BITS-1:0]   tx_seq,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  ack_in,
    input  logic [SEQ_BITS-1:0]   ack_seq,
    output logic [SEQ_BITS-1:0]   outstanding,
    output logic                  retx_pulse,
    output logic                  link_fail
);

    localparam int IW    = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam int DEPTH = 2 ** IW;
    localparam int TW    = $clog2(TIMEOUT);
    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam logic [SEQ_BITS-1:0] WIN = SEQ_BITS'(WINDOW_SIZE);

    typedef enum logic [1:0] {IDLE, ACTIVE, FAIL} state_t;

    state_t              state_q, state_d;
    logic [SEQ_BITS-1:0] base_q, base_d, send_q, send_d, hi_q, hi_d, next_q, next_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [DATA_WIDTH-1:0] buf_q [DEPTH];

    logic                acc_fire, tx_fire, ack_valid, timeout;
    logic [SEQ_BITS-1:0] ack_dist, new_base, send_adv;

    assign outstanding = next_q - base_q;
    assign link_fail   = (state_q == FAIL);
    assign ready_out   = (outstanding < WIN) && !link_fail;
    assign tx_valid    = (send_q != next_q) && !link_fail;
    assign tx_seq      = send_q;
    assign tx_data     = buf_q[send_q[IW-1:0]];

    assign acc_fire  = valid_in && ready_out;
    assign tx_fire   = tx_valid && tx_ready;
    assign send_adv  = tx_fire ? send_q + SEQ_BITS'(1) : send_q;
    // Only ACKs for frames that have actually been sent and are still unacked count.
    assign ack_dist  = ack_seq - base_q;
    assign ack_valid = ack_in && !link_fail && (ack_dist < (hi_q - base_q));
    assign new_base  = ack_seq + SEQ_BITS'(1);
    assign timeout   = !link_fail && (base_q != hi_q) &&
                       (timer_q == TW'(TIMEOUT - 1)) && !ack_valid;
    assign retx_pulse = timeout;

    always_comb begin
        base_d  = base_q;
        send_d  = send_q;
        hi_d    = hi_q;
        next_d  = next_q;
        timer_d = timer_q;
        retry_d = retry_q;
        state_d = state_q;
        if (state_q != FAIL) begin
            if (acc_fire) begin
                next_d = next_q + SEQ_BITS'(1);
            end
            if (ack_valid) begin
                base_d  = new_base;
                hi_d    = (tx_fire && send_q == hi_q) ? hi_q + SEQ_BITS'(1) : hi_q;
                send_d  = ((send_adv - base_q) < (new_base - base_q)) ? new_base : send_adv;
                timer_d = '0;
                retry_d = '0;
                if (new_base == hi_d) begin
                    state_d = IDLE;
                end else if (tx_fire) begin
                    state_d = ACTIVE;
                end
            end else if (timeout) begin
                // Go-back overrides any transmit handshake in this cycle.
                send_d  = base_q;
                timer_d = '0;
                if (retry_q == RW'(MAX_RETRY - 1)) begin
                    state_d = FAIL;
                end else begin
                    retry_d = retry_q + RW'(1);
                end
            end else begin
                timer_d = (base_q != hi_q) ? timer_q + TW'(1) : '0;
                if (tx_fire) begin
                    send_d = send_adv;
                    if (send_q == hi_q) begin
                        hi_d = hi_q + SEQ_BITS'(1);
                    end
                    if (state_q == IDLE) begin
                        state_d = ACTIVE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            send_q  <= '0;
            hi_q    <= '0;
            next_q  <= '0;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            send_q  <= send_d;
            hi_q    <= hi_d;
            next_q  <= next_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (acc_fire) begin
            buf_q[next_q[IW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_gbn_tx_scheduler.sv
// Bench for gbn_tx_scheduler: directed scenarios plus random traffic, all compared
// cycle by cycle against an absolute-sequence-number reference model.
module tb_gbn_tx_scheduler;

    localparam int DW  = 8;
    localparam int SB  = 3;
    localparam int WIN = 4;
    localparam int TMO = 16;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] tx_data;
    logic [SB-1:0] tx_seq;
    logic          tx_valid;
    logic          tx_ready;
    logic          ack_in;
    logic [SB-1:0] ack_seq;
    logic [SB-1:0] outstanding;
    logic          retx_pulse;
    logic          link_fail;

    always #5 clk = ~clk;

    gbn_tx_scheduler #(
        .DATA_WIDTH(DW), .SEQ_BITS(SB), .WINDOW_SIZE(WIN), .TIMEOUT(TMO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .tx_data(tx_data), .tx_seq(tx_seq), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ack_in(ack_in), .ack_seq(ack_seq), .outstanding(outstanding),
        .retx_pulse(retx_pulse), .link_fail(link_fail)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: unbounded absolute frame numbers, reduced mod 8 only at the ports.
    int         m_base, m_send, m_hi, m_next, m_timer, m_retry;
    bit         m_fail;
    logic [7:0] m_pay [$];

    logic [17:0] dut_vec;
    assign dut_vec = {ready_out, tx_valid, tx_seq, (tx_valid ? tx_data : 8'h00),
                      outstanding, retx_pulse, link_fail};

    function automatic bit model_ack_ok();
        int d;
        d = (int'(ack_seq) - (m_base % 8) + 8) % 8;
        return ack_in && !m_fail && (d < (m_hi - m_base));
    endfunction

    function automatic bit model_timeout();
        return !m_fail && (m_hi != m_base) && (m_timer == TMO - 1) && !model_ack_ok();
    endfunction

    function automatic logic [17:0] model_vec();
        int         o;
        bit         r, v;
        logic [7:0] d;
        o = m_next - m_base;
        r = (o < WIN) && !m_fail;
        v = (m_send != m_next) && !m_fail;
        d = v ? m_pay[m_send] : 8'h00;
        return {r, v, 3'(m_send % 8), d, 3'(o), model_timeout(), m_fail};
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock.
    task automatic step();
        bit acc, txf, ack_ok, tmo;
        int d, nb, s, h;
        if (rst) begin
            m_base = 0; m_send = 0; m_hi = 0; m_next = 0;
            m_timer = 0; m_retry = 0; m_fail = 0;
            m_pay.delete();
        end else if (!m_fail) begin
            acc    = valid_in && ((m_next - m_base) < WIN);
            txf    = tx_ready && (m_send != m_next);
            ack_ok = model_ack_ok();
            tmo    = model_timeout();
            if (acc) begin
                m_pay.push_back(data_in);
                m_next++;
            end
            if (ack_ok) begin
                d  = (int'(ack_seq) - (m_base % 8) + 8) % 8;
                nb = m_base + d + 1;
                s  = m_send + (txf ? 1 : 0);
                h  = m_hi + ((txf && m_send == m_hi) ? 1 : 0);
                m_base  = nb;
                m_send  = (s < nb) ? nb : s;
                m_hi    = h;
                m_timer = 0;
                m_retry = 0;
            end else if (tmo) begin
                m_send  = m_base;
                m_timer = 0;
                if (m_retry + 1 == MR) m_fail = 1;
                else m_retry++;
            end else begin
                m_timer = (m_hi != m_base) ? m_timer + 1 : 0;
                if (txf) begin
                    if (m_send == m_hi) m_hi++;
                    m_send++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        tx_ready = 1'b0; ack_in = 1'b0; ack_seq = 3'd0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (dut_vec !== 18'b1_0_000_00000000_000_0_0) begin
            n_fail++; $display("FAIL reset_outputs dut=%h exp=%h", dut_vec, 18'b1_0_000_00000000_000_0_0);
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_tx_data dut=%h exp=00", tx_data);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic_flow();
        logic [10:0] seen [$];
        bit          saw_retx = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            quiet(); tx_ready = 1'b1;
            if (c < 3) begin valid_in = 1'b1; data_in = 8'(8'hA0 + c); end
            if (c == 6) begin ack_in = 1'b1; ack_seq = 3'd2; end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL basic_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (tx_valid && tx_ready) seen.push_back({tx_seq, tx_data});
            if (retx_pulse) saw_retx = 1;
            step();
        end
        #1;
        n_checks++;
        if (seen.size() != 3) begin
            n_fail++; $display("FAIL basic_tx_count got=%0d exp=3", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            n_checks++;
            if (seen[i] !== {3'(i), 8'(8'hA0 + i)}) begin
                n_fail++; $display("FAIL basic_tx_frame i=%0d got=%h exp=%h", i, seen[i], {3'(i), 8'(8'hA0 + i)});
            end
        end
        n_checks++;
        if (outstanding !== 3'd0 || saw_retx) begin
            n_fail++; $display("FAIL basic_final outstanding=%0d retx_seen=%0d exp 0/0", outstanding, saw_retx);
        end
        $display("test_basic_flow: %0d frames sent", seen.size());
    endtask

    task automatic test_window_full();
        logic [10:0] seen [$];
        int          pushed = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            quiet();
            valid_in = (pushed < 5); data_in = 8'(8'hB0 + pushed);
            tx_ready = (c == 6) || (c >= 9);
            if (c == 7) begin ack_in = 1'b1; ack_seq = 3'd0; end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL window_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (c == 5) begin
                n_checks++;
                if ({ready_out, outstanding} !== {1'b0, 3'd4} || pushed != 4) begin
                    n_fail++; $display("FAIL window_full ready=%0d outstanding=%0d pushed=%0d exp 0/4/4", ready_out, outstanding, pushed);
                end
            end
            if (c == 8) begin
                n_checks++;
                if (ready_out !== 1'b1) begin
                    n_fail++; $display("FAIL window_reopen ready=%0d exp=1", ready_out);
                end
            end
            if (valid_in && ready_out) pushed++;
            if (tx_valid && tx_ready) seen.push_back({tx_seq, tx_data});
            step();
        end
        n_checks++;
        if (seen.size() != 5) begin
            n_fail++; $display("FAIL window_tx_count got=%0d exp=5", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            n_checks++;
            if (seen[i] !== {3'(i), 8'(8'hB0 + i)}) begin
                n_fail++; $display("FAIL window_tx_frame i=%0d got=%h exp=%h", i, seen[i], {3'(i), 8'(8'hB0 + i)});
            end
        end
        $display("test_window_full: %0d frames sent", seen.size());
    endtask

    task automatic test_timeout_goback();
        bit got = 0;
        int pulse_cyc = -1;
        do_reset();
        for (int c = 0; c < 40 && !got; c++) begin
            quiet(); tx_ready = 1'b1;
            if (c < 4) begin valid_in = 1'b1; data_in = 8'(8'hA0 + c); end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL timeout_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (retx_pulse) begin got = 1; pulse_cyc = c; end
            step();
        end
        n_checks++;
        if (pulse_cyc != 17) begin
            n_fail++; $display("FAIL timeout_cycle got=%0d exp=17", pulse_cyc);
        end
        quiet(); tx_ready = 1'b1; ack_in = 1'b1; ack_seq = 3'd1;
        #1;
        n_checks++;
        if ({tx_valid, tx_seq, tx_data} !== {1'b1, 3'd0, 8'hA0}) begin
            n_fail++; $display("FAIL goback_resume got=%h exp=%h", {tx_valid, tx_seq, tx_data}, {1'b1, 3'd0, 8'hA0});
        end
        step();
        quiet();
        #1;
        n_checks++;
        if ({tx_valid, tx_seq, tx_data, outstanding} !== {1'b1, 3'd2, 8'hA2, 3'd2}) begin
            n_fail++; $display("FAIL goback_ack_jump got=%h exp=%h", {tx_valid, tx_seq, tx_data, outstanding}, {1'b1, 3'd2, 8'hA2, 3'd2});
        end
        step();
        ack_in = 1'b1; ack_seq = 3'd3;
        step();
        quiet();
        #1;
        n_checks++;
        if (outstanding !== 3'd0) begin
            n_fail++; $display("FAIL goback_drain outstanding=%0d exp=0", outstanding);
        end
        $display("test_timeout_goback: pulse at cycle %0d", pulse_cyc);
    endtask

    task automatic test_stale_ack();
        int pulse_cyc = -1;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            quiet(); tx_ready = 1'b1;
            if (c < 4) begin valid_in = 1'b1; data_in = 8'(8'hC0 + c); end
            if (c == 6) begin ack_in = 1'b1; ack_seq = 3'd1; end
            if (c == 7) begin ack_in = 1'b1; ack_seq = 3'd1; end
            if (c == 8) begin ack_in = 1'b1; ack_seq = 3'd6; end
            if (c == 9) begin ack_in = 1'b1; ack_seq = 3'd4; end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL stale_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (c == 10) begin
                n_checks++;
                if ({tx_valid, outstanding} !== {1'b0, 3'd2}) begin
                    n_fail++; $display("FAIL stale_no_change tx_valid=%0d outstanding=%0d exp 0/2", tx_valid, outstanding);
                end
            end
            if (retx_pulse && pulse_cyc < 0) pulse_cyc = c;
            step();
        end
        n_checks++;
        if (pulse_cyc != 22) begin
            n_fail++; $display("FAIL stale_timer_kept pulse_cycle=%0d exp=22", pulse_cyc);
        end
        $display("test_stale_ack: pulse at cycle %0d", pulse_cyc);
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_data [20];
        logic [10:0] seen [$];
        int          pushed = 0;
        int          max_out = 0;
        for (int i = 0; i < 20; i++) exp_data[i] = 8'($urandom);
        do_reset();
        for (int c = 0; c < 100 && seen.size() < 20; c++) begin
            quiet(); tx_ready = 1'b1;
            if (pushed < 20) begin valid_in = 1'b1; data_in = exp_data[pushed]; end
            if (m_hi > m_base) begin ack_in = 1'b1; ack_seq = 3'(m_hi - 1); end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL wrap_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            if (valid_in && ready_out) pushed++;
            if (tx_valid && tx_ready) seen.push_back({tx_seq, tx_data});
            step();
        end
        n_checks++;
        if (seen.size() != 20 || max_out > WIN) begin
            n_fail++; $display("FAIL wrap_count sent=%0d max_outstanding=%0d exp 20/<=4", seen.size(), max_out);
        end
        for (int i = 0; i < seen.size() && i < 20; i++) begin
            n_checks++;
            if (seen[i] !== {3'(i), exp_data[i]}) begin
                n_fail++; $display("FAIL wrap_frame i=%0d got=%h exp=%h", i, seen[i], {3'(i), exp_data[i]});
            end
        end
        $display("test_wrap: %0d frames sent, max outstanding %0d", seen.size(), max_out);
    endtask

    task automatic test_link_fail();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            quiet(); tx_ready = 1'b1; valid_in = 1'b1; data_in = 8'($urandom);
            if (m_fail) begin ack_in = 1'b1; ack_seq = 3'(m_base); end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL fail_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (retx_pulse) pulses++;
            step();
        end
        #1;
        n_checks++;
        if ({link_fail, tx_valid, ready_out} !== 3'b100 || pulses != MR) begin
            n_fail++; $display("FAIL link_fail_state fail/txv/rdy=%b pulses=%0d exp 100/%0d", {link_fail, tx_valid, ready_out}, pulses, MR);
        end
        do_reset();
        #1;
        n_checks++;
        if ({link_fail, tx_valid, ready_out, outstanding} !== {3'b001, 3'd0}) begin
            n_fail++; $display("FAIL link_fail_clear got=%b exp=001000", {link_fail, tx_valid, ready_out, outstanding});
        end
        $display("test_link_fail: %0d timeouts before failure", pulses);
    endtask

    task automatic test_ack_on_timeout();
        int next_pulse = -1;
        do_reset();
        for (int c = 0; c < 45; c++) begin
            quiet(); tx_ready = 1'b1;
            if (c < 2) begin valid_in = 1'b1; data_in = 8'(8'hD0 + c); end
            if (c == 17) begin ack_in = 1'b1; ack_seq = 3'd0; end
            #1;
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL ackto_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
            end
            if (c == 17) begin
                n_checks++;
                if (retx_pulse !== 1'b0) begin
                    n_fail++; $display("FAIL ackto_no_retx retx_pulse=%0d exp=0", retx_pulse);
                end
            end
            if (c > 17 && retx_pulse && next_pulse < 0) next_pulse = c;
            step();
        end
        n_checks++;
        if (next_pulse != 33) begin
            n_fail++; $display("FAIL ackto_timer_restart next_pulse=%0d exp=33", next_pulse);
        end
        $display("test_ack_on_timeout: next timeout at cycle %0d", next_pulse);
    endtask

    task automatic test_random();
        int sent = 0;
        int timeouts = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            quiet();
            rst      = (c % 600 == 599);
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            ack_in   = ($urandom_range(0, 5) == 0);
            ack_seq  = 3'(m_base + int'($urandom_range(0, 5)));
            #1;
            if (!rst) begin
                n_checks++;
                if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL random_lockstep cyc=%0d dut=%h exp=%h", c, dut_vec, model_vec());
                end
                if (tx_valid && tx_ready) sent++;
                if (retx_pulse) timeouts++;
            end
            step();
        end
        $display("test_random: %0d tx handshakes, %0d timeouts", sent, timeouts);
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_flow();
        test_window_full();
        test_timeout_goback();
        test_stale_ack();
        test_wrap();
        test_link_fail();
        test_ack_on_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/gbn_tx_scheduler.md
Name: gbn_tx_scheduler

Overview:
Go-Back-N transmit scheduler that sits between the data source and the link sender. It buffers up to WINDOW_SIZE unacknowledged frames and assigns each a modular sequence number. It sequences first transmissions onto the link, consumes cumulative ACKs, and on timeout rewinds to the oldest unacked frame and retransmits. After MAX_RETRY consecutive timeouts with no ACK progress, it declares link failure.

Parameters:
DATA_WIDTH, 8, frame payload width
SEQ_BITS, 3, sequence number width; numbers wrap mod 2^SEQ_BITS
WINDOW_SIZE, 4, max outstanding frames; power of 2, must be <= 2^SEQ_BITS-1
TIMEOUT, 16, cycles without ACK progress before go-back (>=2)
MAX_RETRY, 3, consecutive timeouts before link_fail

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
data_in  in  DATA_WIDTH  new frame payload
valid_in  in  1  data_in valid
ready_out  out  1  frame accepted when valid_in&&ready_out
tx_data  out  DATA_WIDTH  frame payload to link sender
tx_seq  out  SEQ_BITS  sequence number of tx_data
tx_valid  out  1  frame presented to link
tx_ready  in  1  link takes frame when tx_valid&&tx_ready
ack_in  in  1  cumulative ACK strobe
ack_seq  in  SEQ_BITS  highest in-order seq received by peer
outstanding  out  SEQ_BITS  next_seq-base (0..WINDOW_SIZE)
retx_pulse  out  1  one-cycle pulse on each timeout/go-back
link_fail  out  1  sticky failure flag

Behaviour:
- Pointers, all SEQ_BITS wide and mod 2^SEQ_BITS: base (oldest unacked), send_ptr (next to transmit), hi_ptr (one past highest ever sent), next_seq (next free slot). Invariant: base <= send_ptr <= hi_ptr <= next_seq in modular distance from base.
- Buffer: WINDOW_SIZE x DATA_WIDTH registers indexed by seq[log2(WINDOW_SIZE)-1:0].
- Reset: all pointers 0, timer 0, retry count 0, state IDLE. Outputs: ready_out=1, tx_valid=0, tx_seq=0, tx_data=0, outstanding=0, retx_pulse=0, link_fail=0.
- Accept: ready_out = (outstanding < WINDOW_SIZE) && state != FAIL. On handshake, write buf[next_seq] and increment next_seq. A frame written in cycle N is presentable on tx in cycle N+1.
- Transmit: tx_valid = (send_ptr != next_seq) && state != FAIL. tx_seq = send_ptr and tx_data = buf[send_ptr], both combinational from registers. On tx handshake, increment send_ptr. If send_ptr == hi_ptr, also increment hi_ptr.
- ACK: ack_in is valid only if d = ack_seq - base (mod) < hi_ptr - base. Otherwise ignore it: stale, duplicate or unsent ACKs produce no state change. On a valid ACK:
  - base <= ack_seq+1.
  - If send_ptr lies behind the new base, send_ptr <= new base.
  - Timer <= 0; retry count <= 0.
- Timer: counts only while base != hi_ptr (sent-but-unacked frames exist). Held at 0 otherwise.
- Timeout: when the timer reaches TIMEOUT-1 and no valid ACK occurs in that cycle:
  - send_ptr <= base; timer <= 0; retry count +1; retx_pulse = 1 for that cycle.
  - A tx handshake in the same cycle is discarded; the go-back wins.
- FSM states:
  - IDLE: base == hi_ptr. Go to ACTIVE on the first tx handshake.
  - ACTIVE: return to IDLE when a valid ACK makes base == hi_ptr.
  - FAIL: entered when a timeout would take the retry count to MAX_RETRY. link_fail=1, tx_valid=0, ready_out=0. Only rst exits FAIL.
- Simultaneous events: valid ACK + timeout in the same cycle → ACK wins, no retransmit. Accept, transmit and ACK in the same cycle all take effect together. outstanding reflects registered pointers.
- Go-back may change tx_seq/tx_data while tx_valid=1 and tx_ready=0; the link sender must tolerate this.
- Reset mid-operation discards all buffered frames and returns to the reset values above on the next edge.

Test Plan:
- Basic flow: push 0xA0,0xA1,0xA2, tx_ready=1 → tx_seq 0,1,2 with matching data; ack_seq=2 → outstanding=0, state IDLE, retx_pulse never asserted.
- Window full: push 5 frames with tx_ready=0 → ready_out drops after 4 accepts, outstanding=4; ack_seq=0 (after tx of seq0) → ready_out=1 and the 5th frame gets seq 4.
- Timeout go-back: send seq 0..3, no ACK → after 16 cycles retx_pulse=1 and tx resumes at seq 0 with data 0xA0; ack_seq=1 mid-retransmit → send_ptr jumps to 2 if behind.
- Stale/invalid ACK: base=2, ack_seq=1 or ack_seq=6 (unsent) → no pointer or timer change.
- Wrap: stream 20 frames with immediate ACKs → tx_seq wraps 7→0, data integrity preserved, outstanding never >4.
- Failure and simultaneity: no ACKs for 3 timeouts → link_fail=1, tx_valid=0, ready_out=0 until rst. Separately, ACK on the exact timeout cycle → no retx_pulse, timer restarts.
